// File: rtl/rvfi_trace_fifo.sv
// Buffers one record per RVFI retirement and streams each record as five 32-bit words.
// Also tracks records lost to a full FIFO and gaps in the retirement order.
module rvfi_trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   rvfi_valid,
  input  logic [63:0]            rvfi_order,
  input  logic [31:0]            rvfi_insn,
  input  logic                   rvfi_trap,
  input  logic [31:0]            rvfi_pc_rdata,
  input  logic [4:0]             rvfi_rd_addr,
  input  logic [31:0]            rvfi_rd_wdata,
  input  logic [31:0]            rvfi_mem_addr,
  input  logic [3:0]             rvfi_mem_rmask,
  input  logic [3:0]             rvfi_mem_wmask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic                   out_last,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   order_err,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              lost_q, lost_d;
  logic              seen_q, seen_d;
  logic [63:0]       last_order_q, last_order_d;
  logic              order_err_q, order_err_d;

  // Entry layout: word k of the record lives at bits [32*k +: 32].
  logic [159:0]      mem_q [DEPTH];
  logic [159:0]      wr_entry;
  logic [159:0]      head;

  logic evt, push, pop, drop, full;

  always_comb begin
    evt  = rvfi_valid & enable;
    full = (level_q == LW'(DEPTH));
    pop  = (state_q == StSend) && (idx_q == 3'd4) && out_ready;
    // When full, the slot being freed by the final handshake can be reused this cycle.
    push = evt && (!full || pop);
    drop = evt && !push;

    wr_entry = {rvfi_mem_addr, rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata,
                lost_q, rvfi_trap, rvfi_rd_addr, rvfi_mem_rmask, rvfi_mem_wmask,
                1'b0, rvfi_order[15:0]};

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end

    drop_d = drop_q;
    if (drop && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_W'(1);
    end

    lost_d = lost_q;
    if (push) begin
      lost_d = 1'b0;
    end else if (drop) begin
      lost_d = 1'b1;
    end

    // Dropped events still advance order tracking so gaps are judged on the RVFI stream itself.
    seen_d       = seen_q;
    last_order_d = last_order_q;
    order_err_d  = order_err_q;
    if (evt) begin
      if (seen_q && (rvfi_order != last_order_q + 64'd1)) begin
        order_err_d = 1'b1;
      end
      last_order_d = rvfi_order;
      seen_d       = 1'b1;
    end

    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (level_q != '0) begin
          state_d = StSend;
          idx_d   = 3'd0;
        end
      end
      StSend: begin
        if (out_ready) begin
          if (idx_q == 3'd4) begin
            idx_d   = 3'd0;
            state_d = (level_d != '0) ? StSend : StIdle;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      idx_q        <= 3'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      drop_q       <= '0;
      lost_q       <= 1'b0;
      seen_q       <= 1'b0;
      last_order_q <= '0;
      order_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      drop_q       <= drop_d;
      lost_q       <= lost_d;
      seen_q       <= seen_d;
      last_order_q <= last_order_d;
      order_err_q  <= order_err_d;
    end
  end

  // Storage needs no reset: only entries counted by level are ever read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = (state_q == StSend);
    out_last  = out_valid && (idx_q == 3'd4);
    out_data  = 32'd0;
    if (out_valid) begin
      unique case (idx_q)
        3'd0:    out_data = head[31:0];
        3'd1:    out_data = head[63:32];
        3'd2:    out_data = head[95:64];
        3'd3:    out_data = head[127:96];
        3'd4:    out_data = head[159:128];
        default: out_data = 32'd0;
      endcase
    end
  end

  assign drop_count = drop_q;
  assign order_err  = order_err_q;
  assign level      = level_q;

endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// Directed bench for rvfi_trace_fifo: one task per scenario, inline comparisons.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rvfi_trace_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic [31:0] rvfi_pc_rdata;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [15:0] drop_count;
  logic        order_err;
  logic [3:0]  level;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] got_w [5];
  logic        got_l [5];
  logic        tmo;

  always #5 clock = ~clock;

  rvfi_trace_fifo #(.DEPTH(8), .CNT_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .rvfi_valid     (rvfi_valid),
    .rvfi_order     (rvfi_order),
    .rvfi_insn      (rvfi_insn),
    .rvfi_trap      (rvfi_trap),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_mem_addr  (rvfi_mem_addr),
    .rvfi_mem_rmask (rvfi_mem_rmask),
    .rvfi_mem_wmask (rvfi_mem_wmask),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .drop_count     (drop_count),
    .order_err      (order_err),
    .level          (level)
  );

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Presents one RVFI event for exactly one rising edge; returns on the following falling edge.
  task automatic send_event(input logic [63:0] ord, input logic [31:0] pc, input logic [31:0] insn,
                            input logic [4:0] rd, input logic [31:0] wd, input logic trap,
                            input logic [3:0] rmask, input logic [3:0] wmask,
                            input logic [31:0] maddr);
    rvfi_valid     = 1'b1;
    rvfi_order     = ord;
    rvfi_pc_rdata  = pc;
    rvfi_insn      = insn;
    rvfi_rd_addr   = rd;
    rvfi_rd_wdata  = wd;
    rvfi_trap      = trap;
    rvfi_mem_rmask = rmask;
    rvfi_mem_wmask = wmask;
    rvfi_mem_addr  = maddr;
    @(negedge clock);
    rvfi_valid = 1'b0;
  endtask

  // Bounded wait for out_valid; sets tmo if it never comes.
  task automatic wait_valid();
    int waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!out_valid) tmo = 1'b1;
  endtask

  // Captures n handshaked words with out_ready held high by the caller.
  task automatic collect_words(input int n);
    for (int k = 0; k < n; k++) begin
      wait_valid();
      got_w[k] = out_data;
      got_l[k] = out_last;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    @(negedge clock);
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b want 0", out_last); end
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    n_cmp++; if (order_err !== 1'b0) begin n_bad++; $display("FAIL reset_order_err got %b want 0", order_err); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single();
    logic [31:0] exp_w [5];
    exp_w[0] = 32'h02000000; exp_w[1] = 32'h80000000; exp_w[2] = 32'h00100093;
    exp_w[3] = 32'h00000001; exp_w[4] = 32'h00000000;
    do_reset();
    enable = 1'b1; out_ready = 1'b1; tmo = 1'b0;
    send_event(64'd0, 32'h80000000, 32'h00100093, 5'd1, 32'd1, 1'b0, 4'h0, 4'h0, 32'h0);
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL single_level_push got %0d want 1", level); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_latency got %b want 0", out_valid); end
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency1 got %b want 1", out_valid); end
    collect_words(5);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL single_timeout got %b want 0", tmo); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (got_w[k] !== exp_w[k]) begin
        n_bad++; $display("FAIL single_word%0d got %h want %h", k, got_w[k], exp_w[k]);
      end
      n_cmp++;
      if (got_l[k] !== (k == 4)) begin
        n_bad++; $display("FAIL single_last%0d got %b want %b", k, got_l[k], (k == 4));
      end
    end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL single_level_end got %0d want 0", level); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_idle got %b want 0", out_valid); end
  endtask

  task automatic test_header_fields();
    do_reset();
    enable = 1'b1; out_ready = 1'b1; tmo = 1'b0;
    send_event(64'h0000_1234_5678_ABCD, 32'h00000010, 32'hDEADBEEF, 5'd31, 32'hCAFEF00D, 1'b1,
               4'hF, 4'h5, 32'h20000004);
    collect_words(5);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL hdr_timeout got %b want 0", tmo); end
    n_cmp++; if (got_w[0] !== 32'h7FEAABCD) begin n_bad++; $display("FAIL hdr_word0 got %h want 7feaabcd", got_w[0]); end
    n_cmp++; if (got_w[3] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL hdr_wdata got %h want cafef00d", got_w[3]); end
    n_cmp++; if (got_w[4] !== 32'h20000004) begin n_bad++; $display("FAIL hdr_maddr got %h want 20000004", got_w[4]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1; out_ready = 1'b1; tmo = 1'b0;
    send_event(64'd0, 32'h80000000, 32'h00100093, 5'd1, 32'd1, 1'b0, 4'h0, 4'h0, 32'h0);
    wait_valid();
    @(negedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    n_cmp++; if (out_data !== 32'h00100093) begin n_bad++; $display("FAIL bp_word2 got %h want 00100093", out_data); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h00100093 || out_last !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold%0d got v=%b d=%h l=%b want v=1 d=00100093 l=0",
                          c, out_valid, out_data, out_last);
      end
    end
    out_ready = 1'b1;
    collect_words(3);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL bp_timeout got %b want 0", tmo); end
    n_cmp++;
    if (got_w[0] !== 32'h00100093 || got_w[1] !== 32'h1 || got_w[2] !== 32'h0) begin
      n_bad++; $display("FAIL bp_resume got %h %h %h want 00100093 00000001 00000000",
                        got_w[0], got_w[1], got_w[2]);
    end
    n_cmp++;
    if (got_l[0] !== 1'b0 || got_l[1] !== 1'b0 || got_l[2] !== 1'b1) begin
      n_bad++; $display("FAIL bp_last got %b%b%b want 001", got_l[0], got_l[1], got_l[2]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1; out_ready = 1'b0; tmo = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_event(64'(i), 32'h1000 + 32'(i) * 4, 32'(i), 5'(i), 32'(i), 1'b0, 4'h0, 4'h0, 32'h0);
    end
    n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL ovf_level got %0d want 8", level); end
    n_cmp++; if (drop_count !== 16'd2) begin n_bad++; $display("FAIL ovf_drop got %0d want 2", drop_count); end
    n_cmp++; if (order_err !== 1'b0) begin n_bad++; $display("FAIL ovf_order_err got %b want 0", order_err); end
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      collect_words(5);
      n_cmp++;
      if (got_w[0][15:0] !== 16'(r) || got_w[0][31] !== 1'b0) begin
        n_bad++; $display("FAIL ovf_rec%0d_hdr got %h want order %0d lost 0", r, got_w[0], r);
      end
      n_cmp++;
      if (got_w[1] !== 32'h1000 + 32'(r) * 4) begin
        n_bad++; $display("FAIL ovf_rec%0d_pc got %h want %h", r, got_w[1], 32'h1000 + 32'(r) * 4);
      end
    end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL ovf_drained got %0d want 0", level); end
    send_event(64'd10, 32'h2000, 32'h13, 5'd10, 32'd10, 1'b0, 4'h0, 4'h0, 32'h0);
    collect_words(5);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL ovf_timeout got %b want 0", tmo); end
    n_cmp++; if (got_w[0] !== 32'h9400000A) begin n_bad++; $display("FAIL ovf_lost_hdr got %h want 9400000a", got_w[0]); end
    n_cmp++; if (order_err !== 1'b0) begin n_bad++; $display("FAIL ovf_order_after got %b want 0", order_err); end
  endtask

  task automatic test_full_pop();
    do_reset();
    enable = 1'b1; out_ready = 1'b0; tmo = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_event(64'(i), 32'h3000 + 32'(i), 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    end
    wait_valid();
    out_ready = 1'b1;
    repeat (4) @(negedge clock);
    n_cmp++; if (out_last !== 1'b1 || level !== 4'd8) begin
      n_bad++; $display("FAIL fp_setup got last=%b level=%0d want last=1 level=8", out_last, level);
    end
    send_event(64'd8, 32'h3008, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL fp_level got %0d want 8", level); end
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL fp_drop got %0d want 0", drop_count); end
    for (int r = 1; r <= 8; r++) begin
      collect_words(5);
      n_cmp++;
      if (got_w[0][15:0] !== 16'(r) || got_w[0][31] !== 1'b0 || got_w[1] !== 32'h3000 + 32'(r)) begin
        n_bad++; $display("FAIL fp_rec%0d got hdr=%h pc=%h want order %0d lost 0", r, got_w[0], got_w[1], r);
      end
    end
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL fp_timeout got %b want 0", tmo); end
  endtask

  task automatic test_order_gap();
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    send_event(64'd5, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    send_event(64'd6, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    n_cmp++; if (order_err !== 1'b0) begin n_bad++; $display("FAIL gap_before got %b want 0", order_err); end
    send_event(64'd8, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    n_cmp++; if (order_err !== 1'b1) begin n_bad++; $display("FAIL gap_set got %b want 1", order_err); end
    send_event(64'd9, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    send_event(64'd10, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    n_cmp++; if (order_err !== 1'b1) begin n_bad++; $display("FAIL gap_sticky got %b want 1", order_err); end
  endtask

  task automatic test_enable_reset();
    do_reset();
    enable = 1'b0; out_ready = 1'b0; tmo = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_event(64'(100 + i), 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    end
    @(negedge clock);
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL en_level got %0d want 0", level); end
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL en_drop got %0d want 0", drop_count); end
    n_cmp++; if (order_err !== 1'b0) begin n_bad++; $display("FAIL en_order got %b want 0", order_err); end
    enable = 1'b1;
    send_event(64'd0, 32'h4000, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    send_event(64'd5, 32'h4004, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    n_cmp++; if (order_err !== 1'b1) begin n_bad++; $display("FAIL en_gap got %b want 1", order_err); end
    wait_valid();
    out_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (tmo !== 1'b0 || out_data !== 32'h4000) begin
      n_bad++; $display("FAIL en_midrec got tmo=%b data=%h want tmo=0 data=00004000", tmo, out_data);
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL rst_level got %0d want 0", level); end
    n_cmp++; if (order_err !== 1'b0) begin n_bad++; $display("FAIL rst_order got %b want 0", order_err); end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0 || level !== 4'd0) begin
      n_bad++; $display("FAIL rst_after got valid=%b level=%0d want 0 0", out_valid, level);
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; rvfi_valid = 1'b0; rvfi_order = '0; rvfi_insn = '0;
    rvfi_trap = 1'b0; rvfi_pc_rdata = '0; rvfi_rd_addr = '0; rvfi_rd_wdata = '0;
    rvfi_mem_addr = '0; rvfi_mem_rmask = '0; rvfi_mem_wmask = '0; out_ready = 1'b0; tmo = 1'b0;
    @(negedge clock);
    test_reset();
    test_single();
    test_header_fields();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_order_gap();
    test_enable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rvfi_trace_fifo.md
Name: rvfi_trace_fifo

Overview:
- Downstream consumer of the hart's RVFI retirement port.
- Captures one record per retired instruction, buffers records in a FIFO, and serialises each record as five 32-bit words over a valid/ready stream.
- The stream feeds the trace UART/debug bridge.
- Tracks dropped records and RVFI order discontinuities for bring-up and formal sanity checks.

Parameters:
- DEPTH, 8, FIFO capacity in records; power of two, minimum 2.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous active-low reset: asserting low resets immediately; release is synchronous to clock.
- enable  in  1  capture enable; when low, RVFI records are ignored and not counted as drops.
- rvfi_valid  in  1  retirement strobe.
- rvfi_order  in  64  retirement index.
- rvfi_insn  in  32  instruction word.
- rvfi_trap  in  1  trap flag.
- rvfi_pc_rdata  in  32  PC of the retired instruction.
- rvfi_rd_addr  in  5  destination register.
- rvfi_rd_wdata  in  32  destination write data.
- rvfi_mem_addr  in  32  memory address.
- rvfi_mem_rmask  in  4  read byte mask.
- rvfi_mem_wmask  in  4  write byte mask.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream sink ready.
- out_data  out  32  stream word.
- out_last  out  1  high on word 4 of each record.
- drop_count  out  CNT_W  records lost to FIFO full; saturates at all-ones.
- order_err  out  1  sticky flag: order discontinuity seen.
- level  out  $clog2(DEPTH)+1  records currently stored.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, drop_count=0, order_err=0, level=0. FIFO pointers are 0, the FSM is in IDLE, the lost flag is 0, and the order-tracking "seen" bit is 0.
- Capture: an RVFI event is rvfi_valid & enable.
- Push condition: an event pushes a record when level<DEPTH, or when level==DEPTH and the final word of the head record handshakes in the same cycle (pop-completes). Simultaneous push and pop leaves level unchanged.
- Record words, in order:
  - word 0 header: [31] lost, [30] trap, [29:25] rd_addr, [24:21] mem_rmask, [20:17] mem_wmask, [16] 0, [15:0] order[15:0].
  - word 1: pc_rdata.
  - word 2: insn.
  - word 3: rd_wdata.
  - word 4: mem_addr.
- Drop: an event that cannot push increments drop_count (saturating) and sets the lost flag. The next successfully pushed record carries lost=1 in its header, and the lost flag then clears. If a drop and a push cannot coincide, the lost flag needs no priority rule.
- Order check, evaluated on every event including dropped ones:
  - If "seen"=1 and rvfi_order != last_order+1 (64-bit wrapping add), set order_err.
  - Every event updates last_order and sets "seen".
  - order_err clears only on reset.
  - Deasserting enable does not clear "seen", so a gap across an enable-low window flags order_err.
- Serialiser FSM:
  - IDLE: out_valid=0. Go to SEND with idx=0 when level>0.
  - SEND: out_valid=1 and out_data = word[idx] of the head record. On out_valid&out_ready:
    - if idx<4: idx++.
    - if idx==4: pop; go to SEND idx=0 if level after pop > 0, else IDLE.
- Stream rules:
  - out_data and out_last are held stable while out_valid & !out_ready.
  - out_valid never drops without a handshake.
  - out_last = (idx==4) & out_valid.
- Latency: a record pushed at edge N has out_valid high after edge N+1 when the FIFO was empty. Back-to-back records stream with no idle cycle.
- Outputs are registered or driven from registers; there is no combinational path from RVFI inputs to out_*.
- Pointers wrap modulo DEPTH; level distinguishes full from empty.
- Reset mid-record: the partial record is abandoned and all state returns to reset values. The sink sees out_valid fall asynchronously.

Test Plan:
- Single record: reset, enable=1, one event with order=0, pc=0x80000000, insn=0x00100093, rd=1, wdata=1, trap=0, masks=0 -> five words with out_ready=1: 0x02000000, 0x80000000, 0x00100093, 0x00000001, 0x00000000; out_last high on word 5 only; level returns to 0.
- Backpressure: out_ready low for 10 cycles while word 2 is presented -> out_data stays 0x00100093 and out_valid stays 1; the stream resumes correctly when out_ready rises.
- Overflow: DEPTH=8, out_ready=0, 10 consecutive events with orders 0..9 -> level=8, drop_count=2, order_err=0. Then out_ready=1 -> 8 records with orders 0..7, all with lost=0. One further event with order=10 -> its header has lost=1.
- Full plus simultaneous pop: level=8, event arrives in the same cycle as the final word handshake -> record accepted, level stays 8, drop_count unchanged.
- Order gap: events with orders 5, 6, 8 -> order_err=1 after the third event and stays set through subsequent contiguous events.
- Enable and reset: enable=0 with 3 events -> level=0, drop_count=0. Then assert reset low mid-record -> out_valid=0 and level=0 immediately, and order_err=0.
